// File: rtl/rvx_core_instruction_queue_pkg.sv
// Shared constants and entry layout for the
// fetch-to-decode instruction queue.
package rvx_core_instruction_queue_pkg;

  localparam logic [2:0] RISCV_I_TYPE_IMMEDIATE   = 3'b001;
  localparam logic [2:0] RISCV_S_TYPE_IMMEDIATE   = 3'b010;
  localparam logic [2:0] RISCV_B_TYPE_IMMEDIATE   = 3'b011;
  localparam logic [2:0] RISCV_U_TYPE_IMMEDIATE   = 3'b100;
  localparam logic [2:0] RISCV_J_TYPE_IMMEDIATE   = 3'b101;
  localparam logic [2:0] RISCV_CSR_TYPE_IMMEDIATE = 3'b110;

  localparam logic [6:0] RVX_OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] RVX_OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] RVX_OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] RVX_OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] RVX_OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] RVX_OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] RVX_OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] RVX_OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] RVX_OPCODE_SYSTEM = 7'b1110011;

  localparam logic [31:0] RVX_NOP_INSTRUCTION = 32'h00000013;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [2:0]  immediate_type;
  } iq_entry_t;

endpackage

// File: rtl/rvx_core_immediate_type_decode.sv
// Opcode/funct3 to immediate-format select.
// Pure combinational; shared with the decoder.
module rvx_core_immediate_type_decode
  import rvx_core_instruction_queue_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [6:0] opcode,
  output logic [2:0] immediate_type
);

  logic is_i;
  logic is_s;
  logic is_b;
  logic is_u;
  logic is_j;
  logic is_csr;

  assign is_i = (opcode == RVX_OPCODE_OP_IMM)
              | (opcode == RVX_OPCODE_LOAD)
              | (opcode == RVX_OPCODE_JALR);
  assign is_s = opcode == RVX_OPCODE_STORE;
  assign is_b = opcode == RVX_OPCODE_BRANCH;
  assign is_u = (opcode == RVX_OPCODE_LUI)
              | (opcode == RVX_OPCODE_AUIPC);
  assign is_j = opcode == RVX_OPCODE_JAL;
  // immediate CSR forms are funct3 1xx
  assign is_csr = (opcode == RVX_OPCODE_SYSTEM)
                & (funct3 >= 3'b100);

  // one-hot select; unknown opcodes fall back to I
  always_comb begin
    immediate_type = RISCV_I_TYPE_IMMEDIATE;
    unique case (1'b1)
      is_i:    immediate_type = RISCV_I_TYPE_IMMEDIATE;
      is_s:    immediate_type = RISCV_S_TYPE_IMMEDIATE;
      is_b:    immediate_type = RISCV_B_TYPE_IMMEDIATE;
      is_u:    immediate_type = RISCV_U_TYPE_IMMEDIATE;
      is_j:    immediate_type = RISCV_J_TYPE_IMMEDIATE;
      is_csr:  immediate_type = RISCV_CSR_TYPE_IMMEDIATE;
      default: immediate_type = RISCV_I_TYPE_IMMEDIATE;
    endcase
  end

endmodule

// File: rtl/rvx_core_instruction_queue.sv
// Fetch-to-decode FIFO; immediate format is
// classified at enqueue so stage 1 sees a register.
module rvx_core_instruction_queue
  import rvx_core_instruction_queue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush_s1,
  input  logic        fetch_valid_s0,
  input  logic [31:0] fetch_instruction_s0,
  input  logic [31:0] fetch_pc_s0,
  output logic        fetch_ready_s0,
  output logic        instruction_valid_s1,
  output logic [24:0] instruction_31_7_s1,
  output logic [6:0]  instruction_6_0_s1,
  output logic [2:0]  immediate_type_s1,
  output logic [31:0] pc_s1,
  input  logic        instruction_ready_s1,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic [2:0]    dec_type;
  iq_entry_t     head;
  iq_entry_t     mem [DEPTH];

  rvx_core_immediate_type_decode u_dec (
    .funct3         (fetch_instruction_s0[14:12]),
    .opcode         (fetch_instruction_s0[6:0]),
    .immediate_type (dec_type)
  );

  assign fetch_ready_s0       = count != FULL;
  assign instruction_valid_s1 = count != '0;
  assign occupancy            = count;

  assign push = fetch_valid_s0 & fetch_ready_s0
              & ~flush_s1;
  assign pop  = instruction_valid_s1
              & instruction_ready_s1 & ~flush_s1;

  // pointer/count bookkeeping; flush wins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush_s1) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage write; contents not reset
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= '{
        instruction:    fetch_instruction_s0,
        pc:             fetch_pc_s0,
        immediate_type: dec_type
      };
    end
  end

  // head entry, or a NOP when empty
  always_comb begin
    head = mem[rd_ptr];
    if (!instruction_valid_s1) begin
      head = '{
        instruction:    RVX_NOP_INSTRUCTION,
        pc:             32'd0,
        immediate_type: RISCV_I_TYPE_IMMEDIATE
      };
    end
  end

  assign instruction_31_7_s1 = head.instruction[31:7];
  assign instruction_6_0_s1  = head.instruction[6:0];
  assign immediate_type_s1   = head.immediate_type;
  assign pc_s1               = head.pc;

endmodule
